i2c_mem_arbiter: RTL and testbench
==================================

# i2c_mem_arbiter

Two-port arbiter that shares the single-port `simple_mem` (7-bit address, 8-bit data) between the I2C slave datapath (port 0) and a local host port (port 1). It serialises one access at a time onto the memory's cs/we/addr/data pins and returns read data to the winning requester. It replaces direct cs/we drive from the I2C slave FSM and sits between `i2c_slave` and `simple_mem`.

## Interface
- ADDR_W, 7, memory address width
- DATA_W, 8, memory data width
- RD_LAT, 1, memory read latency in cycles after the cs cycle; legal 1..4

- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset (single clock domain)
- r0_req / r1_req  input  1  access request; held until the matching gnt
- r0_we / r1_we  input  1  1 = write, 0 = read; stable while req is high
- r0_addr / r1_addr  input  ADDR_W  access address; stable while req is high
- r0_wdata / r1_wdata  input  DATA_W  write data; stable while req is high
- r0_gnt / r1_gnt  output  1  one-cycle pulse; access issued this cycle
- r0_rvalid / r1_rvalid  output  1  one-cycle pulse; rdata valid
- r0_rdata / r1_rdata  output  DATA_W  read data; holds until the next read completes for that port
- mem_cs, mem_we  output  1  memory chip select / write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid RD_LAT cycles after the cs cycle
- arb_busy  output  1  high whenever the state is not ARB_IDLE

## Operation
- FSM states: ARB_IDLE, ARB_ACCESS, ARB_WAIT.
- ARB_IDLE:
  - Sample r0_req/r1_req. If any is high, latch the winner index, we, addr and wdata, then go to ARB_ACCESS. Otherwise stay.
- Arbitration is round-robin with a last-winner pointer (reset value 1, so port 0 wins the first tie).
  - Single requester: it wins.
  - Both requesting: the port not equal to the pointer wins.
  - The pointer updates on every grant.
- ARB_ACCESS (exactly one cycle):
  - mem_cs=1; mem_we/mem_addr/mem_wdata come from the latched values.
  - The winner's gnt pulses.
  - Write: next state ARB_IDLE.
  - Read: next state ARB_WAIT, with the latency counter loaded to RD_LAT-1.
- ARB_WAIT:
  - mem_cs=0. Decrement the counter.
  - When the counter is 0, capture mem_rdata into the winner's rdata register, assert its rvalid on the next cycle, and go to ARB_IDLE.
- A requester may deassert req the cycle after gnt.
- Once a request has been sampled in IDLE it is always completed, even if req drops afterwards (protocol violation tolerated).
- Any unreachable state encoding returns to ARB_IDLE with mem_cs=0.
- Reset values (rst_n low at a clk edge):
  - state ARB_IDLE; pointer 1
  - all gnt, rvalid, mem_cs, mem_we = 0
  - mem_addr, mem_wdata, rdata = 0; arb_busy = 0
- Reset during ARB_WAIT discards the in-flight read. No rvalid is produced afterwards.

## Timing
- Request sampled in cycle N:
  - gnt and mem_cs occur in cycle N+1.
  - For a read, the memory returns data in cycle N+1+RD_LAT, and rvalid/rdata appear in cycle N+2+RD_LAT.
- Write throughput: one access per 2 cycles.
- Read occupancy: RD_LAT+2 cycles, including the IDLE sample cycle that coincides with rvalid.
- The arbiter is in IDLE during the rvalid cycle and may sample a new request in that same cycle.
- Worst-case wait for a continuously requesting port (round-robin): one foreign access.
- All outputs are registered. There are no combinational paths from req to gnt or mem_*.

## Configuration
- `MEM_ARB_I2C_PRIO_EN` defined:
  - Strict priority; port 0 (I2C) wins every tie.
  - The pointer logic is compiled out.
  - Port 1 can starve.
- Undefined: round-robin as described above.

## Structure
- Shared package `mem_arb_pkg` holds:
  - typedef `arb_state_e` {ARB_IDLE, ARB_ACCESS, ARB_WAIT}
  - constants `PORT_I2C`=0 and `PORT_HOST`=1
  - default widths ADDR_W=7, DATA_W=8
- One sub-module, `rr_arb2`, is natural: a two-request picker that takes req[1:0] and the pointer and produces the winner index plus a valid flag. Priority mode is selected by the macro.

## Test plan
- Reset, then port 0 writes addr 0x12, data 0xA5 -> gnt0 and mem_cs=1, mem_we=1, mem_addr=0x12, mem_wdata=0xA5 at N+1; back to idle at N+2.
- Port 1 reads 0x12 with RD_LAT=2 and mem_rdata=0xA5 at N+3 -> gnt1 at N+1, rvalid1 at N+4 with r1_rdata=0xA5; r0_rvalid stays 0.
- Both ports request continuously for 6 accesses -> grants alternate 0,1,0,1,0,1. With `MEM_ARB_I2C_PRIO_EN`: port 0 receives all 6 grants.
- rst_n low during ARB_WAIT of a read -> next cycle all outputs 0, state idle, and no rvalid ever follows.
- Port 0 drops req the cycle after the IDLE sample, before gnt -> the access still issues, gnt0 pulses once, and no second access occurs.
- Back-to-back reads on port 0 with RD_LAT=1 -> the second gnt comes 3 cycles after the first, and each rvalid carries that read's own data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the simple_mem arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    // Read-latency counter width; holds RD_LAT-1 for RD_LAT up to 4.
    localparam int LAT_CNT_W = 2;

    localparam logic PORT_I2C  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request picker. Round-robin against a last-winner pointer by default;
// with MEM_ARB_I2C_PRIO_EN defined, port 0 (I2C) wins every tie and the
// pointer input is ignored.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       win_o,
    output logic       vld_o
);

    // Winner select: a lone requester always wins; ties resolved by mode.
    always_comb begin
        vld_o = |req_i;
`ifdef MEM_ARB_I2C_PRIO_EN
        win_o = req_i[PORT_I2C] ? PORT_I2C : PORT_HOST;
`else
        if (&req_i) begin
            win_o = ~ptr_i;
        end else begin
            win_o = req_i[PORT_HOST] ? PORT_HOST : PORT_I2C;
        end
`endif
    end

`ifdef MEM_ARB_I2C_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ptr_i;
`endif

endmodule

// File: rtl/i2c_mem_arbiter.sv
// Shares single-port simple_mem between the I2C slave (port 0) and a local
// host (port 1), one access at a time. All outputs are registered.
// Optional macro MEM_ARB_I2C_PRIO_EN: strict port-0 priority, no pointer.
//
// state      | meaning
// ARB_IDLE   | sample requests, latch winner and its access
// ARB_ACCESS | one cs cycle on the memory, winner's gnt pulses
// ARB_WAIT   | count out read latency, capture mem_rdata at zero
module i2c_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_busy
);

    arb_state_e           state_q, state_d;
    logic                 win_q, win_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                 rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                 cs_q, cs_d, we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    logic                 rr_ptr;
    logic                 pick_win, pick_vld;

    rr_arb2 u_pick (
        .req_i ({r1_req, r0_req}),
        .ptr_i (rr_ptr),
        .win_o (pick_win),
        .vld_o (pick_vld)
    );

`ifdef MEM_ARB_I2C_PRIO_EN
    assign rr_ptr = PORT_HOST;
`else
    logic ptr_q, ptr_d;

    // Last-winner pointer advances whenever a request is accepted.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB_IDLE && pick_vld) begin
            ptr_d = pick_win;
        end
    end

    // Pointer register; reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PORT_HOST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign rr_ptr = ptr_q;
`endif

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        cs_d      = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_ACCESS;
                    win_d   = pick_win;
                    cs_d    = 1'b1;
                    gnt0_d  = (pick_win == PORT_I2C);
                    gnt1_d  = (pick_win == PORT_HOST);
                    if (pick_win == PORT_HOST) begin
                        we_d    = r1_we;
                        addr_d  = r1_addr;
                        wdata_d = r1_wdata;
                    end else begin
                        we_d    = r0_we;
                        addr_d  = r0_addr;
                        wdata_d = r0_wdata;
                    end
                end
            end
            ARB_ACCESS: begin
                // we_q still carries the latched direction during this cycle.
                if (we_q) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_WAIT;
                    cnt_d   = LAT_CNT_W'(RD_LAT - 1);
                end
            end
            ARB_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ARB_IDLE;
                    if (win_q == PORT_HOST) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = mem_rdata;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            win_q     <= PORT_I2C;
            cnt_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign r0_gnt    = gnt0_q;
    assign r1_gnt    = gnt1_q;
    assign r0_rvalid = rvalid0_q;
    assign r1_rvalid = rvalid1_q;
    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;
    assign mem_cs    = cs_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign arb_busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Bench for i2c_mem_arbiter: instance "dut" with RD_LAT=2, instance "dut1"
// with RD_LAT=1; both share the request inputs and each has its own memory.
module tb_i2c_mem_arbiter;

`ifdef MEM_ARB_I2C_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [6:0] r0_addr = 0, r1_addr = 0;
    logic [7:0] r0_wdata = 0, r1_wdata = 0;

    logic       a_g0, a_g1, a_rv0, a_rv1, a_cs, a_we, a_busy;
    logic [7:0] a_rd0, a_rd1, a_wdata, a_mrd;
    logic [6:0] a_addr;
    logic       b_g0, b_g1, b_rv0, b_rv1, b_cs, b_we, b_busy;
    logic [7:0] b_rd0, b_rd1, b_wdata, b_mrd;
    logic [6:0] b_addr;

    i2c_mem_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_gnt(a_g0), .r1_gnt(a_g1), .r0_rvalid(a_rv0), .r1_rvalid(a_rv1),
        .r0_rdata(a_rd0), .r1_rdata(a_rd1),
        .mem_cs(a_cs), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_rdata(a_mrd), .arb_busy(a_busy)
    );

    i2c_mem_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_gnt(b_g0), .r1_gnt(b_g1), .r0_rvalid(b_rv0), .r1_rvalid(b_rv1),
        .r0_rdata(b_rd0), .r1_rdata(b_rd1),
        .mem_cs(b_cs), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_rdata(b_mrd), .arb_busy(b_busy)
    );

    // Memory models: preload mem[a] = a + 0x40; read data valid RD_LAT
    // cycles after the cs cycle, zero otherwise.
    logic [7:0] mem_a [128];
    logic [7:0] mem_b [128];
    logic [7:0] a_p0 = 0, a_p1 = 0, b_p0 = 0;
    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = 8'(i) + 8'h40;
            mem_b[i] = 8'(i) + 8'h40;
        end
    end
    always @(posedge clk) begin
        if (a_cs && a_we) mem_a[a_addr] <= a_wdata;
        a_p0 <= (a_cs && !a_we) ? mem_a[a_addr] : 8'h00;
        a_p1 <= a_p0;
        if (b_cs && b_we) mem_b[b_addr] <= b_wdata;
        b_p0 <= (b_cs && !b_we) ? mem_b[b_addr] : 8'h00;
    end
    assign a_mrd = a_p1;
    assign b_mrd = b_p0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic g0, g1, cs, we,
                           input logic [6:0] ad, input logic [7:0] wd,
                           input logic v0, v1, input logic [7:0] d0, d1,
                           input logic bz);
        chk({tag, " gnt0"}, 32'(a_g0), 32'(g0));
        chk({tag, " gnt1"}, 32'(a_g1), 32'(g1));
        chk({tag, " cs"}, 32'(a_cs), 32'(cs));
        chk({tag, " we"}, 32'(a_we), 32'(we));
        chk({tag, " addr"}, 32'(a_addr), 32'(ad));
        chk({tag, " wdata"}, 32'(a_wdata), 32'(wd));
        chk({tag, " rvalid0"}, 32'(a_rv0), 32'(v0));
        chk({tag, " rvalid1"}, 32'(a_rv1), 32'(v1));
        chk({tag, " rdata0"}, 32'(a_rd0), 32'(d0));
        chk({tag, " rdata1"}, 32'(a_rd1), 32'(d1));
        chk({tag, " busy"}, 32'(a_busy), 32'(bz));
    endtask

    typedef struct {
        logic       q0, w0;  logic [6:0] a0; logic [7:0] d0;
        logic       q1, w1;  logic [6:0] a1; logic [7:0] d1;
        logic       g0, g1, cs, we; logic [6:0] ad; logic [7:0] wd;
        logic       v0, v1;  logic [7:0] rd0, rd1; logic bz;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic q0, w0, input logic [6:0] a0, input logic [7:0] d0,
                       input logic q1, w1, input logic [6:0] a1, input logic [7:0] d1,
                       input logic g0, g1, cs, we, input logic [6:0] ad, input logic [7:0] wd,
                       input logic v0, v1, input logic [7:0] rd0, rd1, input logic bz);
        vec_t v;
        v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.cs = cs; v.we = we; v.ad = ad; v.wd = wd;
        v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1; v.bz = bz;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit p1;
        logic [6:0] ea;
        logic [7:0] ed;
        int ng, ncs, nrv, t1, t2, phase;
        logic [7:0] rvd0, rvd1;

        // Port 0 writes 0x12=0xA5, then port 1 reads 0x12 back (RD_LAT=2).
        add(1,1,7'h12,8'hA5, 0,0,7'h00,8'h00, 0,0,0,0,7'h00,8'h00, 0,0,8'h00,8'h00, 0);
        add(1,1,7'h12,8'hA5, 0,0,7'h00,8'h00, 1,0,1,1,7'h12,8'hA5, 0,0,8'h00,8'h00, 1);
        add(0,0,7'h00,8'h00, 1,0,7'h12,8'h00, 0,0,0,0,7'h12,8'hA5, 0,0,8'h00,8'h00, 0);
        add(0,0,7'h00,8'h00, 1,0,7'h12,8'h00, 0,1,1,0,7'h12,8'h00, 0,0,8'h00,8'h00, 1);
        add(0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,7'h12,8'h00, 0,0,8'h00,8'h00, 1);
        add(0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,7'h12,8'h00, 0,0,8'h00,8'h00, 1);
        add(0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,7'h12,8'h00, 0,1,8'h00,8'hA5, 0);
        add(0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,7'h12,8'h00, 0,0,8'h00,8'hA5, 0);
        // Both ports write continuously for six accesses.
        add(1,1,7'h20,8'h11, 1,1,7'h30,8'h22, 0,0,0,0,7'h12,8'h00, 0,0,8'h00,8'hA5, 0);
        ea = 7'h20; ed = 8'h11;
        for (int k = 0; k < 6; k++) begin
            p1 = (k % 2 == 1) && !PRIO;
            ea = p1 ? 7'h30 : 7'h20;
            ed = p1 ? 8'h22 : 8'h11;
            add(1,1,7'h20,8'h11, 1,1,7'h30,8'h22, !p1,p1,1,1,ea,ed, 0,0,8'h00,8'hA5, 1);
            if (k < 5)
                add(1,1,7'h20,8'h11, 1,1,7'h30,8'h22, 0,0,0,0,ea,ed, 0,0,8'h00,8'hA5, 0);
        end
        add(0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,ea,ed, 0,0,8'h00,8'hA5, 0);
        add(0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,ea,ed, 0,0,8'h00,8'hA5, 0);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0,0,0,0,7'h00,8'h00, 0,0,8'h00,8'h00, 0);
        chk("reset dut1 outs", 32'({b_g0,b_g1,b_rv0,b_rv1,b_cs,b_we,b_busy}), 32'd0);
        chk("reset dut1 data", 32'({b_addr,b_wdata,b_rd0,b_rd1}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            tick();
            r0_req = vq[i].q0; r0_we = vq[i].w0; r0_addr = vq[i].a0; r0_wdata = vq[i].d0;
            r1_req = vq[i].q1; r1_we = vq[i].w1; r1_addr = vq[i].a1; r1_wdata = vq[i].d1;
            @(negedge clk);
            chk_all($sformatf("v%0d", i), vq[i].g0, vq[i].g1, vq[i].cs, vq[i].we, vq[i].ad,
                    vq[i].wd, vq[i].v0, vq[i].v1, vq[i].rd0, vq[i].rd1, vq[i].bz);
        end

        // Reset during ARB_WAIT of a port-0 read discards it.
        tick();
        r0_req = 1; r0_we = 0; r0_addr = 7'h05;
        tick();
        @(negedge clk);
        chk("rstwait gnt0", 32'(a_g0), 32'd1);
        tick();
        r0_req = 0; rst_n = 1'b0;
        @(negedge clk);
        chk("rstwait busy in wait", 32'(a_busy), 32'd1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("rstwait", 0,0,0,0,7'h00,8'h00, 0,0,8'h00,8'h00, 0);
        nrv = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            @(negedge clk);
            nrv += int'(a_rv0) + int'(a_rv1);
        end
        chk("rstwait no rvalid", 32'(nrv), 32'd0);

        // First tie after reset goes to port 0.
        tick();
        r0_req = 1; r0_we = 1; r0_addr = 7'h40; r0_wdata = 8'h01;
        r1_req = 1; r1_we = 1; r1_addr = 7'h41; r1_wdata = 8'h02;
        tick();
        r0_req = 0; r1_req = 0;
        @(negedge clk);
        chk("tie gnt0", 32'(a_g0), 32'd1);
        chk("tie gnt1", 32'(a_g1), 32'd0);
        chk("tie addr", 32'(a_addr), 32'h40);
        repeat (2) tick();

        // Port 0 drops req right after the sample: exactly one access.
        tick();
        r0_req = 1; r0_we = 1; r0_addr = 7'h33; r0_wdata = 8'h77;
        ng = 0; ncs = 0;
        for (int t = 0; t < 7; t++) begin
            tick();
            r0_req = 0;
            @(negedge clk);
            if (t == 0) begin
                chk("drop gnt0 at N+1", 32'(a_g0), 32'd1);
                chk("drop addr", 32'(a_addr), 32'h33);
                chk("drop wdata", 32'(a_wdata), 32'h77);
            end
            ng += int'(a_g0);
            ncs += int'(a_cs);
        end
        chk("drop gnt0 count", 32'(ng), 32'd1);
        chk("drop cs count", 32'(ncs), 32'd1);

        // Back-to-back port-0 reads of 0x01 then 0x02 on the RD_LAT=1 instance.
        phase = 0; ng = 0; nrv = 0; t1 = 0; t2 = 0; rvd0 = 0; rvd1 = 0;
        for (int t = 0; t < 14; t++) begin
            tick();
            r0_req = (phase < 2);
            r0_we = 0;
            r0_addr = (phase == 0) ? 7'h01 : 7'h02;
            @(negedge clk);
            if (b_g0) begin
                ng++;
                if (phase == 0) begin t1 = t; phase = 1; end
                else if (phase == 1) begin t2 = t; phase = 2; end
            end
            if (b_rv0) begin
                if (nrv == 0) rvd0 = b_rd0;
                if (nrv == 1) rvd1 = b_rd0;
                nrv++;
            end
        end
        chk("b2b gnt count", 32'(ng), 32'd2);
        chk("b2b gnt spacing", 32'(t2 - t1), 32'd3);
        chk("b2b rvalid count", 32'(nrv), 32'd2);
        chk("b2b rdata first", 32'(rvd0), 32'h41);
        chk("b2b rdata second", 32'(rvd1), 32'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
